// File: rtl/morse_tx_if.sv
// Character handshake and Morse line bundle between a character source and morse_tx.
interface morse_tx_if;
   logic       valid;
   logic [4:0] letter;
   logic       ready;
   logic       out;
   logic       busy;
   logic       done;

   modport master (output valid, letter, input ready, out, busy, done);
   modport slave  (input valid, letter, output ready, out, busy, done);
endinterface

// File: rtl/morse_tx.sv
// Morse transmitter: takes one character per valid/ready transfer and drives the
// dot/dash/gap line, including the trailing character gap or a 7-unit word space.
module morse_tx #(
   parameter int UNIT_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   morse_tx_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MARK = 2'd1,
      GAP  = 2'd2,
      CGAP = 2'd3
   } state_t;

   localparam logic [7:0] U_LAST = 8'(UNIT_CYCLES - 1);

   // ROM word layout: {word_space, element_count[2:0], pattern[3:0]}, pattern MSB first, 1 = dash
   function automatic logic [7:0] code_rom(input logic [4:0] l);
      case (l)
         5'd0:    code_rom = {1'b0, 3'd2, 4'b0100}; // A .-
         5'd1:    code_rom = {1'b0, 3'd4, 4'b1000}; // B -...
         5'd2:    code_rom = {1'b0, 3'd4, 4'b1010}; // C -.-.
         5'd3:    code_rom = {1'b0, 3'd3, 4'b1000}; // D -..
         5'd4:    code_rom = {1'b0, 3'd1, 4'b0000}; // E .
         5'd5:    code_rom = {1'b0, 3'd4, 4'b0010}; // F ..-.
         5'd6:    code_rom = {1'b0, 3'd3, 4'b1100}; // G --.
         5'd7:    code_rom = {1'b0, 3'd4, 4'b0000}; // H ....
         5'd8:    code_rom = {1'b0, 3'd2, 4'b0000}; // I ..
         5'd9:    code_rom = {1'b0, 3'd4, 4'b0111}; // J .---
         5'd10:   code_rom = {1'b0, 3'd3, 4'b1010}; // K -.-
         5'd11:   code_rom = {1'b0, 3'd4, 4'b0100}; // L .-..
         5'd12:   code_rom = {1'b0, 3'd2, 4'b1100}; // M --
         5'd13:   code_rom = {1'b0, 3'd2, 4'b1000}; // N -.
         5'd14:   code_rom = {1'b0, 3'd3, 4'b1110}; // O ---
         5'd15:   code_rom = {1'b0, 3'd4, 4'b0110}; // P .--.
         5'd16:   code_rom = {1'b0, 3'd4, 4'b1101}; // Q --.-
         5'd17:   code_rom = {1'b0, 3'd3, 4'b0100}; // R .-.
         5'd18:   code_rom = {1'b0, 3'd3, 4'b0000}; // S ...
         5'd19:   code_rom = {1'b0, 3'd1, 4'b1000}; // T -
         5'd20:   code_rom = {1'b0, 3'd3, 4'b0010}; // U ..-
         5'd21:   code_rom = {1'b0, 3'd4, 4'b0001}; // V ...-
         5'd22:   code_rom = {1'b0, 3'd3, 4'b0110}; // W .--
         5'd23:   code_rom = {1'b0, 3'd4, 4'b1001}; // X -..-
         5'd24:   code_rom = {1'b0, 3'd4, 4'b1011}; // Y -.--
         5'd25:   code_rom = {1'b0, 3'd4, 4'b1100}; // Z --..
         default: code_rom = {1'b1, 3'd0, 4'b0000}; // word space
      endcase
   endfunction

   // Index of the final unit of the current segment
   function automatic logic [2:0] last_unit(input state_t s, input logic dash, input logic word);
      case (s)
         MARK:    last_unit = dash ? 3'd2 : 3'd0;
         GAP:     last_unit = 3'd0;
         CGAP:    last_unit = word ? 3'd6 : 3'd2;
         default: last_unit = 3'd0;
      endcase
   endfunction

   function automatic logic seg_end(input state_t s, input logic [7:0] unit, input logic [2:0] dur,
                                    input logic dash, input logic word);
      seg_end = (s != IDLE) && (unit == U_LAST) && (dur == last_unit(s, dash, word));
   endfunction

   state_t     state_q, state_d;
   logic [7:0] unit_q, unit_d;
   logic [2:0] dur_q, dur_d;
   logic [2:0] cnt_q, cnt_d;
   logic [3:0] pat_q, pat_d;
   logic       word_q, word_d;
   logic       out_q, out_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       ready_q, ready_d;
   logic [7:0] rom_s;
   logic       accept_s;
   logic       end_s;
   logic       end_next_s;

   // State and counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         unit_q  <= 8'd0;
         dur_q   <= 3'd0;
         cnt_q   <= 3'd0;
         pat_q   <= 4'd0;
         word_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         unit_q  <= unit_d;
         dur_q   <= dur_d;
         cnt_q   <= cnt_d;
         pat_q   <= pat_d;
         word_q  <= word_d;
      end
   end

   // Next state, counter advance and character load
   always_comb begin
      state_d  = state_q;
      unit_d   = unit_q;
      dur_d    = dur_q;
      cnt_d    = cnt_q;
      pat_d    = pat_q;
      word_d   = word_q;
      rom_s    = code_rom(bus.letter);
      accept_s = bus.valid & ready_q;
      end_s    = seg_end(state_q, unit_q, dur_q, pat_q[3], word_q);

      if (state_q == IDLE || end_s) begin
         unit_d = 8'd0;
         dur_d  = 3'd0;
      end else if (unit_q == U_LAST) begin
         unit_d = 8'd0;
         dur_d  = dur_q + 3'd1;
      end else begin
         unit_d = unit_q + 8'd1;
      end

      case (state_q)
         IDLE: begin
            if (accept_s) state_d = rom_s[7] ? CGAP : MARK;
            else          state_d = IDLE;
         end
         MARK: begin
            if (end_s) state_d = (cnt_q > 3'd1) ? GAP : CGAP;
            else       state_d = MARK;
         end
         GAP: begin
            if (end_s) begin
               state_d = MARK;
               pat_d   = {pat_q[2:0], 1'b0};
               cnt_d   = cnt_q - 3'd1;
            end else begin
               state_d = GAP;
            end
         end
         CGAP: begin
            if (end_s) state_d = accept_s ? (rom_s[7] ? CGAP : MARK) : IDLE;
            else       state_d = CGAP;
         end
         default: state_d = IDLE;
      endcase

      // ready_q is only high in IDLE or the last CGAP cycle, so accept always means a load
      if (accept_s) begin
         word_d = rom_s[7];
         cnt_d  = rom_s[6:4];
         pat_d  = rom_s[3:0];
      end else begin
         word_d = word_d;
      end
   end

   // Output values for the cycle after this edge, taken from the next-state values
   always_comb begin
      end_next_s = seg_end(state_d, unit_d, dur_d, pat_d[3], word_d);
      out_d      = (state_d == MARK);
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == CGAP) && end_next_s;
      ready_d    = (state_d == IDLE) || done_d;
   end

   // Output flops
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         out_q   <= out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign bus.out   = out_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.ready = ready_q;

endmodule
